// File: rtl/cp0_exc.sv
// Coprocessor-0 exception/interrupt controller: Status, Cause and EPC, exception
// arbitration and PC redirect. Define CP0_TIMER_EN to add Count/Compare timer.
module cp0_exc #(
  parameter logic [31:0] EXC_BASE = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] pc4,
  input  logic        ov,
  input  logic        ov_en,
  input  logic        sys,
  input  logic        unimpl,
  input  logic        eret,
  input  logic        mtc0,
  input  logic [4:0]  rd,
  input  logic [31:0] wdata,
  input  logic        intr,
  output logic [31:0] rdata,
  output logic        exc,
  output logic        redirect,
  output logic [31:0] vec,
  output logic        wb_cancel,
  output logic        inta
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  localparam logic [4:0] CODE_INT = 5'd0;
  localparam logic [4:0] CODE_SYS = 5'd8;
  localparam logic [4:0] CODE_UNI = 5'd10;
  localparam logic [4:0] CODE_OV  = 5'd12;

  logic        ie, pie, im_ext, em_sys, em_uni, em_ov;
  logic [4:0]  exc_code;
  logic [31:0] epc;
  logic        sync1, sync2;
  logic        ip_ext;
  logic        im_tmr, ip_tmr;

  logic        hit_uni, hit_sys, hit_ov, sync_hit, int_hit, eret_taken;
  logic [4:0]  sync_code;
  logic        wr_en;

  assign ip_ext = sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= intr;
      sync2 <= sync1;
    end
  end

  always_comb begin
    hit_uni    = unimpl & em_uni;
    hit_sys    = sys & em_sys;
    hit_ov     = ov & ov_en & em_ov;
    sync_hit   = hit_uni | hit_sys | hit_ov;
    sync_code  = hit_uni ? CODE_UNI : (hit_sys ? CODE_SYS : CODE_OV);
    eret_taken = eret & ~sync_hit;
    int_hit    = ie & ((ip_ext & im_ext) | (ip_tmr & im_tmr)) & ~sync_hit & ~eret;
    exc        = sync_hit | int_hit;
    redirect   = exc | eret_taken;
    vec        = exc ? EXC_BASE : epc;
    wb_cancel  = sync_hit;
    inta       = int_hit;
    wr_en      = mtc0 & ~exc;
  end

  // mtc0 is applied first so that exception entry or eret overrides IE/PIE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie       <= 1'b0;
      pie      <= 1'b0;
      im_ext   <= 1'b0;
      em_sys   <= 1'b0;
      em_uni   <= 1'b0;
      em_ov    <= 1'b0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      if (wr_en && rd == REG_STATUS) begin
        ie     <= wdata[0];
        pie    <= wdata[1];
        im_ext <= wdata[8];
        em_sys <= wdata[12];
        em_uni <= wdata[13];
        em_ov  <= wdata[14];
      end
      if (wr_en && rd == REG_EPC)
        epc <= wdata;
      if (sync_hit) begin
        epc      <= pc;
        exc_code <= sync_code;
        pie      <= ie;
        ie       <= 1'b0;
      end else if (int_hit) begin
        epc      <= pc4;
        exc_code <= CODE_INT;
        pie      <= ie;
        ie       <= 1'b0;
      end else if (eret_taken) begin
        ie <= pie;
      end
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count, compare;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      compare <= '0;
      ip_tmr  <= 1'b0;
      im_tmr  <= 1'b0;
    end else begin
      if (wr_en && rd == REG_COUNT)
        count <= wdata;
      else
        count <= count + 32'd1;
      if (wr_en && rd == REG_STATUS)
        im_tmr <= wdata[9];
      // A Compare write both rearms and acknowledges the timer.
      if (wr_en && rd == REG_COMPARE) begin
        compare <= wdata;
        ip_tmr  <= 1'b0;
      end else if (count == compare && compare != '0) begin
        ip_tmr <= 1'b1;
      end
    end
  end
`else
  assign ip_tmr = 1'b0;
  assign im_tmr = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (rd)
      REG_STATUS: rdata = {17'b0, em_ov, em_uni, em_sys, 2'b0, im_tmr, im_ext, 6'b0, pie, ie};
      REG_CAUSE:  rdata = {20'b0, ip_tmr, ip_ext, 3'b0, exc_code, 2'b0};
      REG_EPC:    rdata = epc;
`ifdef CP0_TIMER_EN
      REG_COUNT:   rdata = count;
      REG_COMPARE: rdata = compare;
`endif
      default:    rdata = '0;
    endcase
  end

endmodule

// File: doc/cp0_exc.md
# cp0_exc

Coprocessor-0 exception and interrupt controller for the single-cycle CPU. It consumes the ALU overflow flag and the decoder's syscall and unimplemented-instruction flags, plus an external interrupt line. It holds the Status, Cause and EPC registers, decides each cycle whether to take an exception or return from one, and drives the PC redirect and the writeback cancel for the datapath.

## Interface
- EXC_BASE, 32'h0000_0008: handler entry address.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc  in  32  address of the current instruction.
- pc4  in  32  address of the next sequential instruction.
- ov  in  1  ALU overflow flag for the current instruction.
- ov_en  in  1  current instruction is a trapping add/sub/addi.
- sys  in  1  current instruction is syscall.
- unimpl  in  1  current instruction is unimplemented.
- eret  in  1  current instruction is eret.
- mtc0  in  1  write CP0 register `rd` with `wdata`.
- rd  in  5  CP0 register number for mfc0/mtc0.
- wdata  in  32  mtc0 data.
- intr  in  1  external interrupt request, level-sensitive and asynchronous to clk.
- rdata  out  32  combinational read of CP0 register `rd`.
- exc  out  1  exception or interrupt taken this cycle.
- redirect  out  1  equals exc | eret_taken; the PC loads `vec`.
- vec  out  32  EXC_BASE when exc is high; EPC when eret is taken.
- wb_cancel  out  1  suppress register and memory writeback of the current instruction.
- inta  out  1  interrupt acknowledge; one-cycle pulse when an interrupt is taken.

## Operation
- Register map:
  - 12 Status: [0] IE, [1] PIE, [8] IM_EXT, [9] IM_TMR, [12] EM_SYS, [13] EM_UNI, [14] EM_OV. All other bits read 0 and ignore writes.
  - 13 Cause: [6:2] ExcCode, [10] IP_EXT, [11] IP_TMR. Read-only.
  - 14 EPC: read/write.
  - With timer enabled, also 9 Count and 11 Compare.
  - Unmapped registers read 0; writes to them are ignored.
- intr passes through a 2-flop synchronizer. IP_EXT equals the second flop.
- Synchronous exception candidates, in priority order (highest first):
  - unimpl & EM_UNI: code 10
  - sys & EM_SYS: code 8
  - ov & ov_en & EM_OV: code 12
- Interrupt candidate: IE & ((IP_EXT & IM_EXT) | (IP_TMR & IM_TMR)), with no synchronous candidate and eret low. Code 0.
- Taking a synchronous exception:
  - EPC <= pc; ExcCode <= code; PIE <= IE; IE <= 0.
  - wb_cancel = 1.
- Taking an interrupt:
  - The current instruction completes, so wb_cancel = 0.
  - EPC <= pc4; ExcCode <= 0; PIE <= IE; IE <= 0; inta = 1.
- eret, when no synchronous exception is taken: vec = EPC, IE <= PIE, wb_cancel = 0.
- Masked events produce no exception:
  - An overflowing add completes with the wrapped result.
  - Masked sys and unimpl execute as nop, with wb_cancel = 0.
- mtc0 writes land at the clock edge; mfc0 sees the new value from the next cycle.
- Simultaneous events:
  - exc suppresses an mtc0 in the same cycle.
  - A synchronous exception beats eret.
  - eret beats an interrupt. A still-pending interrupt is taken on the first cycle in which IE reads 1.
- Reset mid-handler clears all state: no pending return, EPC = 0.

## Timing
- Reset values: Status, Cause, EPC, Count and Compare are 0, and the synchronizer flops are 0.
- Output reset values: rdata = 0 when rd is unmapped; exc, redirect, wb_cancel and inta are 0 while no event is present.
- exc, redirect, vec, wb_cancel and inta are combinational from the current-cycle inputs and register state, with zero latency.
- Register updates take effect at the next rising edge.
- Interrupt latency: 2 cycles through the synchronizer, then taken in the cycle IP_EXT is high and enabled. Total 2–3 edges after intr rises.
- inta is high for exactly one cycle per taken interrupt. The source must drop intr before the handler re-enables IE.

## Configuration
- CP0_TIMER_EN defined:
  - Count (reg 9) increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
  - mtc0 to Count loads wdata, with no increment that cycle.
  - IP_TMR sets (sticky) on the edge where Count equals Compare and Compare is nonzero.
  - mtc0 to Compare writes it and clears IP_TMR.
- CP0_TIMER_EN undefined:
  - Registers 9 and 11 are unmapped.
  - IP_TMR and IM_TMR are constant 0.

## Test plan
- Reset, then Status = 0x7101 via mtc0; add with ov = 1, ov_en = 1, pc = 0x40 -> exc = 1, vec = 0x8, wb_cancel = 1. Next cycle: EPC = 0x40, ExcCode = 12, IE = 0, PIE = 1.
- Same overflow with EM_OV = 0 -> exc = 0, wb_cancel = 0, and registers unchanged.
- unimpl, sys and ov all high in one cycle -> ExcCode = 10 only. Then eret -> vec = 0x40, IE restored to 1 next cycle.
- Status = 0x0101, intr raised, pc4 = 0x104 -> inta pulses 2–3 cycles later, EPC = 0x104, wb_cancel = 0, ExcCode = 0.
- eret with intr pending and PIE = 1 -> eret taken first; the interrupt is taken the following cycle with EPC = the eret target's pc4.
- With CP0_TIMER_EN defined: Compare = 5, Count = 0, Status = 0x0201 -> IP_TMR sets when Count reaches 5 and the interrupt is taken. mtc0 Compare clears IP_TMR. Asserting rst mid-count returns Count to 0.
